// File: rtl/top_if_pkg.sv
// -----------------------------------------------------------------------------
// top_if_pkg
// Constants shared by the fetch stage (top_if), the decode stage (top_id) and
// the debug unit, plus the fetch-stage action encoding and a small helper.
// -----------------------------------------------------------------------------
package top_if_pkg;

  localparam int LENGTH_INSTRUCTION = 32;
  localparam int CANT_BITS_ADDR     = 11;
  localparam int CANT_BITS_CONTADOR = 32;

  localparam logic [LENGTH_INSTRUCTION-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF;
  localparam logic [LENGTH_INSTRUCTION-1:0] NOP_INSTRUCTION  = 32'h0000_0000;

  // What the fetch stage does on a given rising edge, in priority order.
  typedef enum logic [2:0] {
    FETCH_FROZEN  = 3'd0,  // pipeline disabled: everything holds
    FETCH_STALL   = 3'd1,  // load-use stall: PC and IF/ID hold
    FETCH_BRANCH  = 3'd2,  // redirect to branch target, flush wrong-path word
    FETCH_HALTED  = 3'd3,  // HALT already fetched: feed bubbles
    FETCH_NORMAL  = 3'd4   // fetch mem[PC] and advance
  } fetch_sel_e;

  function automatic logic is_halt(input logic [LENGTH_INSTRUCTION-1:0] word);
    return (word == HALT_INSTRUCTION);
  endfunction

endpackage

// File: rtl/top_if_if.sv
// -----------------------------------------------------------------------------
// top_if_if
// Bundle of the fetch-stage control/data signals.
//   slave  modport : the fetch stage (top_if) - consumes i_*, produces o_*
//   master modport : the environment (ID stage, hazard unit, debug unit)
// Handshake: there is no valid/ready pair; i_enable_pipeline qualifies every
// rising edge. When it is 1 the stage advances by the priority
// stall > branch > halted > normal fetch; when it is 0 all state holds and only
// debug program-load writes (i_write_mem_enable) take effect.
// -----------------------------------------------------------------------------
interface top_if_if #(
  parameter int LENGTH_INSTRUCTION = top_if_pkg::LENGTH_INSTRUCTION,
  parameter int CANT_BITS_ADDR     = top_if_pkg::CANT_BITS_ADDR,
  parameter int CANT_BITS_CONTADOR = top_if_pkg::CANT_BITS_CONTADOR
);

  logic                          i_enable_pipeline;
  logic                          i_stall_hazard;
  logic                          i_branch_control;
  logic [CANT_BITS_ADDR-1:0]     i_branch_dir;
  logic                          i_write_mem_enable;
  logic [CANT_BITS_ADDR-1:0]     i_addr_mem_debug;
  logic [LENGTH_INSTRUCTION-1:0] i_data_mem_debug;

  logic [LENGTH_INSTRUCTION-1:0] o_instruction;
  logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc;
  logic [CANT_BITS_ADDR-1:0]     o_pc;
  logic                          o_halt_fetched;
  logic [CANT_BITS_CONTADOR-1:0] o_contador_ciclos;

  modport slave (
    input  i_enable_pipeline, i_stall_hazard, i_branch_control, i_branch_dir,
           i_write_mem_enable, i_addr_mem_debug, i_data_mem_debug,
    output o_instruction, o_out_adder_pc, o_pc, o_halt_fetched,
           o_contador_ciclos
  );

  modport master (
    output i_enable_pipeline, i_stall_hazard, i_branch_control, i_branch_dir,
           i_write_mem_enable, i_addr_mem_debug, i_data_mem_debug,
    input  o_instruction, o_out_adder_pc, o_pc, o_halt_fetched,
           o_contador_ciclos
  );

endinterface

// File: rtl/top_if_instruction_memory.sv
// -----------------------------------------------------------------------------
// instruction_memory
// Word-addressed instruction store of depth 2^ADDR_W.
//   i_clock   : write clock
//   i_we      : write enable (sampled on rising edge)
//   i_waddr   : write address
//   i_wdata   : write data
//   i_raddr   : read address (combinational read)
//   o_rdata   : read data
// Contents are deliberately not reset so a loaded program survives a soft reset.
// -----------------------------------------------------------------------------
module instruction_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic              i_clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/top_if.sv
// -----------------------------------------------------------------------------
// top_if
// MIPS instruction fetch stage. Holds the PC and instruction memory, produces
// the IF/ID register (instruction, PC+1), applies branch redirect and hazard
// stall from ID, freezes after fetching HALT and counts executed cycles.
//   i_clock      : clock, all state on rising edge
//   i_soft_reset : asynchronous active-low reset (memory contents kept)
//   bus          : top_if_if.slave - control inputs, debug program-load port,
//                  IF/ID outputs, PC, halt flag and cycle counter
// -----------------------------------------------------------------------------
module top_if #(
  parameter int LENGTH_INSTRUCTION = top_if_pkg::LENGTH_INSTRUCTION,
  parameter int CANT_BITS_ADDR     = top_if_pkg::CANT_BITS_ADDR,
  parameter int CANT_BITS_CONTADOR = top_if_pkg::CANT_BITS_CONTADOR
) (
  input  logic        i_clock,
  input  logic        i_soft_reset,
  top_if_if.slave     bus
);

  import top_if_pkg::*;

  localparam logic [CANT_BITS_ADDR-1:0]     ADDR_ONE = 1;
  localparam logic [CANT_BITS_CONTADOR-1:0] CNT_ONE  = 1;
  localparam logic [LENGTH_INSTRUCTION-1:0] NOP_WORD = NOP_INSTRUCTION;

  logic [CANT_BITS_ADDR-1:0]     pc_q, pc_d;
  logic [LENGTH_INSTRUCTION-1:0] instr_q, instr_d;
  logic [CANT_BITS_ADDR-1:0]     adder_pc_q, adder_pc_d;
  logic                          halt_q, halt_d;
  logic [CANT_BITS_CONTADOR-1:0] cnt_q, cnt_d;

  logic [LENGTH_INSTRUCTION-1:0] mem_word;
  logic [CANT_BITS_ADDR-1:0]     adder;
  logic                          mem_we;
  logic                          word_is_halt;
  fetch_sel_e                    fetch_sel;

  // Program loads only land while the pipeline is stopped so the debug unit
  // can never modify code that is being fetched.
  assign mem_we = bus.i_write_mem_enable & ~bus.i_enable_pipeline;

  instruction_memory #(
    .DATA_W (LENGTH_INSTRUCTION),
    .ADDR_W (CANT_BITS_ADDR)
  ) u_imem (
    .i_clock (i_clock),
    .i_we    (mem_we),
    .i_waddr (bus.i_addr_mem_debug),
    .i_wdata (bus.i_data_mem_debug),
    .i_raddr (pc_q),
    .o_rdata (mem_word)
  );

  // Natural wrap at 2^CANT_BITS_ADDR.
  assign adder        = pc_q + ADDR_ONE;
  assign word_is_halt = is_halt(mem_word);

  always_comb begin
    fetch_sel = FETCH_FROZEN;
    if (bus.i_enable_pipeline) begin
      if (bus.i_stall_hazard)        fetch_sel = FETCH_STALL;
      else if (bus.i_branch_control) fetch_sel = FETCH_BRANCH;
      else if (halt_q)               fetch_sel = FETCH_HALTED;
      else                           fetch_sel = FETCH_NORMAL;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    adder_pc_d = adder_pc_q;
    halt_d     = halt_q;
    cnt_d      = cnt_q;

    // The counter sees the halt flag as it stood before this edge, so the edge
    // that fetches HALT still counts and a branch out of halt does not.
    if (bus.i_enable_pipeline && !halt_q) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    case (fetch_sel)
      FETCH_BRANCH: begin
        pc_d       = bus.i_branch_dir;
        instr_d    = NOP_WORD;
        adder_pc_d = adder;
        halt_d     = 1'b0;  // a HALT fetched on the wrong path is cancelled
      end
      FETCH_HALTED: begin
        instr_d = NOP_WORD;
      end
      FETCH_NORMAL: begin
        instr_d    = mem_word;
        adder_pc_d = adder;
        halt_d     = word_is_halt;
        pc_d       = word_is_halt ? pc_q : adder;
      end
      default: begin
        // FETCH_FROZEN and FETCH_STALL: PC and IF/ID hold.
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      pc_q       <= '0;
      instr_q    <= NOP_WORD;
      adder_pc_q <= '0;
      halt_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      adder_pc_q <= adder_pc_d;
      halt_q     <= halt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.o_instruction     = instr_q;
  assign bus.o_out_adder_pc    = adder_pc_q;
  assign bus.o_pc              = pc_q;
  assign bus.o_halt_fetched    = halt_q;
  assign bus.o_contador_ciclos = cnt_q;

endmodule

// File: tb/tb_top_if.sv
// -----------------------------------------------------------------------------
// tb_top_if
// Directed bench for the fetch stage: program load, straight-line fetch to
// HALT, hazard stall, branch redirect, branch out of halt, PC wrap, write
// blocking while enabled and asynchronous reset mid-run.
// -----------------------------------------------------------------------------
module tb_top_if;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  top_if_if bus_if ();

  top_if dut (
    .i_clock      (clk),
    .i_soft_reset (rst_n),
    .bus          (bus_if.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single comparison
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // all observable outputs at once
  task automatic chk_all(input string tag, input logic [31:0] instr,
                         input logic [10:0] adder_pc, input logic [10:0] pc,
                         input logic halt, input logic [31:0] cnt);
    chk({tag, ".instr"}, 64'(bus_if.o_instruction),     64'(instr));
    chk({tag, ".adder"}, 64'(bus_if.o_out_adder_pc),    64'(adder_pc));
    chk({tag, ".pc"},    64'(bus_if.o_pc),              64'(pc));
    chk({tag, ".halt"},  64'(bus_if.o_halt_fetched),    64'(halt));
    chk({tag, ".cnt"},   64'(bus_if.o_contador_ciclos), 64'(cnt));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [10:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_if.i_write_mem_enable = 1'b1;
    bus_if.i_addr_mem_debug   = addr;
    bus_if.i_data_mem_debug   = data;
    tick();
    bus_if.i_write_mem_enable = 1'b0;
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all(tag, 32'h0, 11'd0, 11'd0, 1'b0, 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_ctl(input logic stall, input logic br, input logic [10:0] dir);
    bus_if.i_stall_hazard   = stall;
    bus_if.i_branch_control = br;
    bus_if.i_branch_dir     = dir;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_if.i_enable_pipeline  = 1'b0;
    bus_if.i_write_mem_enable = 1'b0;
    bus_if.i_addr_mem_debug   = '0;
    bus_if.i_data_mem_debug   = '0;
    set_ctl(1'b0, 1'b0, 11'd0);

    #1;
    chk_all("reset", 32'h0, 11'd0, 11'd0, 1'b0, 32'd0);
    #2;
    rst_n = 1'b1;

    // program load while the pipeline is stopped
    load(11'd0,    32'h2001_0005);
    load(11'd1,    32'h2002_0003);
    load(11'd2,    32'hFFFF_FFFF);
    load(11'h040,  32'h2003_000A);
    load(11'd4,    32'h2004_0004);
    load(11'd5,    32'hFFFF_FFFF);
    load(11'h010,  32'h2005_00AA);
    load(11'd2047, 32'h1234_5678);
    chk_all("load_idle", 32'h0, 11'd0, 11'd0, 1'b0, 32'd0);

    reset_pulse("prerun_rst");

    // straight-line fetch up to HALT
    bus_if.i_enable_pipeline = 1'b1;
    tick(); chk_all("f0",     32'h2001_0005, 11'd1, 11'd1, 1'b0, 32'd1);
    tick(); chk_all("f1",     32'h2002_0003, 11'd2, 11'd2, 1'b0, 32'd2);
    tick(); chk_all("f_halt", 32'hFFFF_FFFF, 11'd3, 11'd2, 1'b1, 32'd3);
    tick(); chk_all("halt_1", 32'h0,         11'd3, 11'd2, 1'b1, 32'd3);
    tick(); chk_all("halt_2", 32'h0,         11'd3, 11'd2, 1'b1, 32'd3);

    // asynchronous reset mid-run: outputs clear at once, program retained
    reset_pulse("mid_rst");

    // hazard stall for two cycles after the first fetch
    tick(); chk_all("s_f0", 32'h2001_0005, 11'd1, 11'd1, 1'b0, 32'd1);
    set_ctl(1'b1, 1'b0, 11'd0);
    tick(); chk_all("stall1", 32'h2001_0005, 11'd1, 11'd1, 1'b0, 32'd2);
    tick(); chk_all("stall2", 32'h2001_0005, 11'd1, 11'd1, 1'b0, 32'd3);
    set_ctl(1'b0, 1'b0, 11'd0);
    tick(); chk_all("s_f1", 32'h2002_0003, 11'd2, 11'd2, 1'b0, 32'd4);

    // stall and branch together: stall wins
    set_ctl(1'b1, 1'b1, 11'h040);
    tick(); chk_all("stall_br", 32'h2002_0003, 11'd2, 11'd2, 1'b0, 32'd5);

    // branch to 0x040: flush, then fetch target
    set_ctl(1'b0, 1'b1, 11'h040);
    tick(); chk_all("br40",    32'h0,         11'd3,    11'h040, 1'b0, 32'd6);
    set_ctl(1'b0, 1'b0, 11'd0);
    tick(); chk_all("br40_f",  32'h2003_000A, 11'h041, 11'h041, 1'b0, 32'd7);

    // branch to 4, fetch into HALT at 5, then branch out of halt to 0x010
    set_ctl(1'b0, 1'b1, 11'd4);
    tick(); chk_all("br4",    32'h0,         11'h042, 11'd4, 1'b0, 32'd8);
    set_ctl(1'b0, 1'b0, 11'd0);
    tick(); chk_all("f4",     32'h2004_0004, 11'd5,   11'd5, 1'b0, 32'd9);
    tick(); chk_all("f5_halt", 32'hFFFF_FFFF, 11'd6,  11'd5, 1'b1, 32'd10);
    set_ctl(1'b0, 1'b1, 11'h010);
    tick(); chk_all("br_unhalt", 32'h0,      11'd6,   11'h010, 1'b0, 32'd10);
    set_ctl(1'b0, 1'b0, 11'd0);
    tick(); chk_all("f10",    32'h2005_00AA, 11'h011, 11'h011, 1'b0, 32'd11);

    // PC wrap at 2047
    set_ctl(1'b0, 1'b1, 11'd2047);
    tick(); chk_all("br_top", 32'h0,         11'h012, 11'd2047, 1'b0, 32'd12);
    set_ctl(1'b0, 1'b0, 11'd0);
    tick(); chk_all("wrap",   32'h1234_5678, 11'd0,   11'd0,    1'b0, 32'd13);
    tick(); chk_all("wrap_f0", 32'h2001_0005, 11'd1,  11'd1,    1'b0, 32'd14);

    // write attempt while enabled must be ignored
    bus_if.i_write_mem_enable = 1'b1;
    bus_if.i_addr_mem_debug   = 11'd1;
    bus_if.i_data_mem_debug   = 32'hDEAD_BEEF;
    tick(); chk_all("wr_en_f1", 32'h2002_0003, 11'd2, 11'd2, 1'b0, 32'd15);
    bus_if.i_write_mem_enable = 1'b0;

    // pipeline disabled: everything holds
    bus_if.i_enable_pipeline = 1'b0;
    tick(); chk_all("disabled", 32'h2002_0003, 11'd2, 11'd2, 1'b0, 32'd15);
    tick(); chk_all("disabled2", 32'h2002_0003, 11'd2, 11'd2, 1'b0, 32'd15);

    // reset and re-fetch: word 1 must still be the original
    reset_pulse("end_rst");
    bus_if.i_enable_pipeline = 1'b1;
    tick(); chk_all("re_f0", 32'h2001_0005, 11'd1, 11'd1, 1'b0, 32'd1);
    tick(); chk_all("re_f1", 32'h2002_0003, 11'd2, 11'd2, 1'b0, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
